// File: rtl/arbiter_bank_if.sv
// Handshake bundle between the source streams, the destination ports and the arbiter bank.
// The arbiter side uses the slave modport; the driving environment uses the master modport.
interface arbiter_bank_if #(
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3
);
    localparam int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;
    localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1;

    logic [T_DEST_WIDTH-1:0] s_dest_i [S_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] s_valid_i;
    logic [S_DATA_COUNT-1:0] s_last_i;
    logic [M_DATA_COUNT-1:0] m_ready_i;
    logic [T_ID___WIDTH-1:0] grant_o [M_DATA_COUNT];
    logic [M_DATA_COUNT-1:0] grant_valid_o;
    logic [S_DATA_COUNT-1:0] s_ready_o;
    logic [M_DATA_COUNT-1:0] wdog_err_o;

    modport master (
        output s_dest_i, s_valid_i, s_last_i, m_ready_i,
        input  grant_o, grant_valid_o, s_ready_o, wdog_err_o
    );

    modport slave (
        input  s_dest_i, s_valid_i, s_last_i, m_ready_i,
        output grant_o, grant_valid_o, s_ready_o, wdog_err_o
    );
endinterface

// File: rtl/arbiter_bank.sv
// Bank of per-destination round-robin packet arbiters; each destination locks onto one source per packet.
// Optional macro ARB_BANK_WATCHDOG_EN adds a per-destination beat watchdog that force-releases long packets.
module arbiter_bank #(
    parameter int S_DATA_COUNT  = 2,
    parameter int M_DATA_COUNT  = 3,
    parameter int MAX_PKT_BEATS = 256
) (
    input  logic          clk_i,
    input  logic          rst_i,
    arbiter_bank_if.slave bus
);
    localparam int T_ID___WIDTH   = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;
    localparam int T_DEST_WIDTH   = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1;
    localparam int BEAT_CNT_WIDTH = $clog2(MAX_PKT_BEATS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic [S_DATA_COUNT-1:0] req [M_DATA_COUNT];
    logic [T_ID___WIDTH-1:0] grant_id [M_DATA_COUNT];
    logic [M_DATA_COUNT-1:0] acc;
    logic [S_DATA_COUNT-1:0] s_ready;

    // Out-of-range parameters leave this empty block as the only trace; it keeps all knobs referenced.
    if (S_DATA_COUNT < 1 || S_DATA_COUNT > 32 || M_DATA_COUNT < 1 || M_DATA_COUNT > 32 ||
        MAX_PKT_BEATS < 2 || MAX_PKT_BEATS > 65535 || BEAT_CNT_WIDTH > 16) begin : g_bad_cfg
    end

    generate
        for (genvar gi = 0; gi < M_DATA_COUNT; gi++) begin : g_dest
            state_t                  state_reg, state_next;
            logic [T_ID___WIDTH-1:0] ptr_reg, ptr_next;
            logic [T_ID___WIDTH-1:0] grant_reg, grant_next;
            logic [T_ID___WIDTH-1:0] pick;
            logic [T_ID___WIDTH-1:0] scan_sel;
            logic                    pick_found;
            logic                    granted_req;
            logic                    granted_last;
            int                      scan_idx;

            for (genvar gj = 0; gj < S_DATA_COUNT; gj++) begin : g_req
                assign req[gi][gj] = bus.s_valid_i[gj] && (bus.s_dest_i[gj] == T_DEST_WIDTH'(gi));
            end

            // Scan from farthest to nearest so the source closest after ptr_reg wins.
            always_comb begin
                pick       = ptr_reg;
                pick_found = 1'b0;
                scan_idx   = 0;
                scan_sel   = '0;
                for (int k = S_DATA_COUNT; k >= 1; k--) begin
                    scan_idx = int'(ptr_reg) + k;
                    if (scan_idx >= S_DATA_COUNT) begin
                        scan_idx = scan_idx - S_DATA_COUNT;
                    end
                    scan_sel = T_ID___WIDTH'(scan_idx);
                    if (req[gi][scan_sel]) begin
                        pick       = scan_sel;
                        pick_found = 1'b1;
                    end
                end
            end

            assign granted_req  = req[gi][grant_reg];
            assign granted_last = bus.s_last_i[grant_reg];
            assign acc[gi]      = (state_reg == LOCKED) && granted_req && bus.m_ready_i[gi];
            assign grant_id[gi] = grant_reg;

            assign bus.grant_o[gi]       = grant_reg;
            assign bus.grant_valid_o[gi] = (state_reg == LOCKED);

`ifdef ARB_BANK_WATCHDOG_EN
            logic [BEAT_CNT_WIDTH-1:0] cnt_reg, cnt_next;
            logic                      wdog_reg, wdog_next;

            assign bus.wdog_err_o[gi] = wdog_reg;
`else
            assign bus.wdog_err_o[gi] = 1'b0;
`endif

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_reg <= IDLE;
                    ptr_reg   <= T_ID___WIDTH'(S_DATA_COUNT - 1);
                    grant_reg <= '0;
`ifdef ARB_BANK_WATCHDOG_EN
                    cnt_reg   <= '0;
                    wdog_reg  <= 1'b0;
`endif
                end else begin
                    state_reg <= state_next;
                    ptr_reg   <= ptr_next;
                    grant_reg <= grant_next;
`ifdef ARB_BANK_WATCHDOG_EN
                    cnt_reg   <= cnt_next;
                    wdog_reg  <= wdog_next;
`endif
                end
            end

            always_comb begin
                state_next = state_reg;
                ptr_next   = ptr_reg;
                grant_next = grant_reg;
`ifdef ARB_BANK_WATCHDOG_EN
                cnt_next   = cnt_reg;
                wdog_next  = 1'b0;
`endif
                case (state_reg)
                    IDLE: begin
                        if (pick_found) begin
                            state_next = LOCKED;
                            grant_next = pick;
`ifdef ARB_BANK_WATCHDOG_EN
                            cnt_next   = '0;
`endif
                        end
                    end
                    LOCKED: begin
                        if (acc[gi]) begin
                            if (granted_last) begin
                                state_next = IDLE;
                                ptr_next   = grant_reg;
                            end
`ifdef ARB_BANK_WATCHDOG_EN
                            else if (cnt_reg == BEAT_CNT_WIDTH'(MAX_PKT_BEATS - 1)) begin
                                state_next = IDLE;
                                ptr_next   = grant_reg;
                                wdog_next  = 1'b1;
                            end else if (cnt_reg != {BEAT_CNT_WIDTH{1'b1}}) begin
                                cnt_next = cnt_reg + BEAT_CNT_WIDTH'(1);
                            end
`endif
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    endgenerate

    // A source targets a single destination, so at most one acc term can match each source.
    always_comb begin
        s_ready = '0;
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (acc[i] && (grant_id[i] == T_ID___WIDTH'(j))) begin
                    s_ready[j] = 1'b1;
                end
            end
        end
    end

    assign bus.s_ready_o = s_ready;

endmodule

// File: doc/arbiter_bank.md
ARBITER_BANK -- requirements
Module: arbiter_bank

Interface
REQ-001 SHALL have parameter S_DATA_COUNT, default 2, number of source (slave-side) streams, legal range 1..32.
REQ-002 SHALL have parameter M_DATA_COUNT, default 3, number of destination (master-side) ports, legal range 1..32.
REQ-003 SHALL have parameter MAX_PKT_BEATS, default 256, watchdog beat limit per packet, legal range 2..65535.
REQ-004 SHALL derive localparams T_ID___WIDTH = max(1,$clog2(S_DATA_COUNT)), T_DEST_WIDTH = max(1,$clog2(M_DATA_COUNT)), BEAT_CNT_WIDTH = $clog2(MAX_PKT_BEATS+1).
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 s_dest_i  input  [T_DEST_WIDTH-1:0] x S_DATA_COUNT (unpacked)  per-source destination port index.
REQ-008 s_valid_i  input  S_DATA_COUNT  per-source beat valid.
REQ-009 s_last_i  input  S_DATA_COUNT  per-source last beat of packet.
REQ-010 m_ready_i  input  M_DATA_COUNT  per-destination downstream ready.
REQ-011 grant_o  output  [T_ID___WIDTH-1:0] x M_DATA_COUNT (unpacked)  granted source id per destination.
REQ-012 grant_valid_o  output  M_DATA_COUNT  destination currently locked to grant_o[i].
REQ-013 s_ready_o  output  S_DATA_COUNT  per-source beat accept.
REQ-014 wdog_err_o  output  M_DATA_COUNT  one-cycle pulse on watchdog release (only with macro, else tied 0).

Function
REQ-015 Request mask per destination i SHALL be req[i][j] = s_valid_i[j] && (s_dest_i[j] == i); out-of-range dest values request nothing.
REQ-016 Each destination SHALL run an independent FSM, states IDLE and LOCKED, plus a last-served pointer ptr[i].
REQ-017 IDLE: if req[i] nonzero, SHALL select first requesting j scanning ptr[i]+1, ptr[i]+2, ... modulo S_DATA_COUNT, register grant_o[i]=j, go LOCKED next cycle; else stay IDLE.
REQ-018 Grant latency SHALL be exactly 1 cycle from request visible in IDLE to grant_valid_o[i]=1.
REQ-019 LOCKED: grant_o[i] SHALL stay constant; other sources' requests SHALL be ignored.
REQ-020 Beat accept for destination i: acc[i] = grant_valid_o[i] && req[i][grant_o[i]] && m_ready_i[i].
REQ-021 s_ready_o[j] SHALL be combinational = OR over i of (acc[i] && grant_o[i]==j); no s_valid->s_ready dependency beyond req.
REQ-022 On acc[i] with s_last_i[grant_o[i]]=1, SHALL go IDLE next cycle and set ptr[i]=grant_o[i]; one idle bubble cycle per packet boundary is required.
REQ-023 Granted source deasserting valid or changing dest mid-packet SHALL hold LOCKED with no accepts until its request returns.
REQ-024 S_DATA_COUNT=1: grant_o SHALL be 0; FSM and handshake behave identically.
REQ-025 Distinct destinations granting different sources in the same cycle SHALL be independent; a source SHALL never be accepted by two destinations (single dest per source).

Reset
REQ-026 While rst_i=1 at clk edge: all FSMs IDLE, ptr[i]=S_DATA_COUNT-1 (source 0 highest priority first), beat counters 0.
REQ-027 Outputs after reset: grant_o=0, grant_valid_o=0, s_ready_o=0, wdog_err_o=0; reset mid-packet SHALL abandon the packet without error pulse.

Configuration
REQ-028 Macro ARB_BANK_WATCHDOG_EN SHALL compile in per-destination beat counter: cleared on entering LOCKED, +1 per acc[i] without last, saturating.
REQ-029 With macro: acc[i] without last when counter = MAX_PKT_BEATS-1 SHALL force IDLE next cycle, ptr[i]=grant_o[i], wdog_err_o[i]=1 for one cycle.
REQ-030 Without macro: no counter logic, wdog_err_o tied 0, lock persists until last.

Verification
REQ-031 S=2,M=3, reset, src0 dest=1 valid, last on 3rd beat, m_ready=1 -> grant_valid_o[1]=1 one cycle later, grant_o[1]=0, 3 s_ready_o[0] pulses, IDLE after.
REQ-032 src0 and src1 both dest=2 with 1-beat packets continuous -> grants alternate 0,1,0,1 with one bubble between.
REQ-033 Locked to src1, m_ready_i[0]=0 for 4 cycles -> s_ready_o[1]=0 those cycles, grant_o[0] unchanged, src0 request ignored.
REQ-034 src0 dest=0, src1 dest=2 same cycle -> both destinations grant in same cycle, s_ready_o=2'b11 when both ready.
REQ-035 ARB_BANK_WATCHDOG_EN, MAX_PKT_BEATS=4, 6 beats without last -> 4 accepts, wdog_err_o pulse, FSM IDLE, regrant.
REQ-036 rst_i asserted mid-packet (beat 2 of 5) -> next cycle all outputs 0, new request regranted with source 0 priority.
